// File: rtl/gshare_choice_predictor.sv
// gshare_choice_predictor
//   Global pattern table (GP) and choice table (CP) of saturating counters,
//   indexed by global history (optionally XOR-hashed with the branch PC).
//   Owns the global history register. Produces the final tournament
//   prediction from GP, CP and the local predictor's result. Updates use a
//   two-stage read-modify-write (U1 read, U2 write) with forwarding, so
//   back-to-back updates never stall.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-high reset
//   ready             high once both tables have been cleared after reset
//   pred_*  (in)      prediction request: valid, PC, local prediction
//   pred_*  (out)     registered result: valid pulse, GP msb, CP msb,
//                     final taken, index used (returned on update)
//   upd_*             branch resolution: valid, index, outcome, and the
//                     global/local predictions originally made
module gshare_choice_predictor #(
    parameter int unsigned HIST_BITS = 12,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned HASH_MODE = 1,
    parameter int unsigned PC_BITS   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 pred_valid,
    input  logic [PC_BITS-1:0]   pred_pc,
    input  logic                 pred_lp,
    output logic                 pred_out_valid,
    output logic                 pred_gp,
    output logic                 pred_cp,
    output logic                 pred_taken,
    output logic [HIST_BITS-1:0] pred_index,
    input  logic                 upd_valid,
    input  logic [HIST_BITS-1:0] upd_index,
    input  logic                 upd_taken,
    input  logic                 upd_gp,
    input  logic                 upd_lp
);

    localparam int unsigned DEPTH = 1 << HIST_BITS;
    localparam int unsigned MSB   = CTR_BITS - 1;

    typedef logic [CTR_BITS-1:0]  ctr_t;
    typedef logic [HIST_BITS-1:0] idx_t;
    typedef enum logic {INIT, RUN} state_t;

    localparam ctr_t CTR_MAX  = '1;
    localparam ctr_t CTR_ZERO = '0;
    localparam idx_t IDX_LAST = '1;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_ZERO) ? c : c - CTR_BITS'(1);
    endfunction

    ctr_t gp_tbl_q [DEPTH];
    ctr_t cp_tbl_q [DEPTH];

    state_t state_q, state_d;
    idx_t   init_ptr_q, init_ptr_d;
    idx_t   ghr_q, ghr_d;
    logic   ready_q, ready_d;
    logic   pred_out_valid_q, pred_out_valid_d;
    logic   pred_gp_q, pred_gp_d;
    logic   pred_cp_q, pred_cp_d;
    logic   pred_taken_q, pred_taken_d;
    idx_t   pred_index_q, pred_index_d;
    logic   u1_valid_q, u1_valid_d;
    idx_t   u1_idx_q, u1_idx_d;
    logic   u1_taken_q, u1_taken_d;
    logic   u1_gp_q, u1_gp_d;
    logic   u1_lp_q, u1_lp_d;
    ctr_t   u1_gpc_q, u1_gpc_d;
    ctr_t   u1_cpc_q, u1_cpc_d;

    ctr_t   u2_gp_new_c, u2_cp_new_c;
    idx_t   pc_lo_c, pred_idx_c;
    ctr_t   pred_gpc_c, pred_cpc_c, upd_gpc_c, upd_cpc_c;
    logic   tbl_we_c;
    idx_t   tbl_wa_c;
    ctr_t   gp_wd_c, cp_wd_c;
    logic   unused_pc_c;

    // Upper PC bits never reach the index.
    assign unused_pc_c = ^pred_pc;

    assign pc_lo_c    = pred_pc[HIST_BITS-1:0];
    assign pred_idx_c = (HASH_MODE != 0) ? (ghr_q ^ pc_lo_c) : ghr_q;

    // U2: new counter values from the U1 snapshot.
    always_comb begin
        u2_gp_new_c = u1_taken_q ? sat_inc(u1_gpc_q) : sat_dec(u1_gpc_q);
        u2_cp_new_c = u1_cpc_q;
        if ((u1_gp_q == u1_taken_q) && (u1_lp_q != u1_taken_q)) begin
            u2_cp_new_c = sat_inc(u1_cpc_q);
        end else if ((u1_gp_q != u1_taken_q) && (u1_lp_q == u1_taken_q)) begin
            u2_cp_new_c = sat_dec(u1_cpc_q);
        end
    end

    // Table reads with U2 forwarding for both the prediction and U1 ports.
    always_comb begin
        pred_gpc_c = gp_tbl_q[pred_idx_c];
        pred_cpc_c = cp_tbl_q[pred_idx_c];
        upd_gpc_c  = gp_tbl_q[upd_index];
        upd_cpc_c  = cp_tbl_q[upd_index];
        if (u1_valid_q && (u1_idx_q == pred_idx_c)) begin
            pred_gpc_c = u2_gp_new_c;
            pred_cpc_c = u2_cp_new_c;
        end
        if (u1_valid_q && (u1_idx_q == upd_index)) begin
            upd_gpc_c = u2_gp_new_c;
            upd_cpc_c = u2_cp_new_c;
        end
    end

    // Single write port: clearing during INIT, U2 write-back during RUN.
    always_comb begin
        tbl_we_c = 1'b0;
        tbl_wa_c = u1_idx_q;
        gp_wd_c  = u2_gp_new_c;
        cp_wd_c  = u2_cp_new_c;
        if (!reset) begin
            if (state_q == INIT) begin
                tbl_we_c = 1'b1;
                tbl_wa_c = init_ptr_q;
                gp_wd_c  = CTR_ZERO;
                cp_wd_c  = CTR_ZERO;
            end else if (u1_valid_q) begin
                tbl_we_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (tbl_we_c) begin
            gp_tbl_q[tbl_wa_c] <= gp_wd_c;
            cp_tbl_q[tbl_wa_c] <= cp_wd_c;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d          = state_q;
        init_ptr_d       = init_ptr_q;
        ghr_d            = ghr_q;
        ready_d          = (state_q == RUN);
        pred_out_valid_d = 1'b0;
        pred_gp_d        = pred_gp_q;
        pred_cp_d        = pred_cp_q;
        pred_taken_d     = pred_taken_q;
        pred_index_d     = pred_index_q;
        u1_valid_d       = 1'b0;
        u1_idx_d         = u1_idx_q;
        u1_taken_d       = u1_taken_q;
        u1_gp_d          = u1_gp_q;
        u1_lp_d          = u1_lp_q;
        u1_gpc_d         = u1_gpc_q;
        u1_cpc_d         = u1_cpc_q;
        case (state_q)
            INIT: begin
                init_ptr_d = init_ptr_q + HIST_BITS'(1);
                if (init_ptr_q == IDX_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // ready_q trails the INIT->RUN step by one edge; requests wait for it.
                if (pred_valid && ready_q) begin
                    pred_out_valid_d = 1'b1;
                    pred_index_d     = pred_idx_c;
                    pred_gp_d        = pred_gpc_c[MSB];
                    pred_cp_d        = pred_cpc_c[MSB];
                    pred_taken_d     = pred_cpc_c[MSB] ? pred_gpc_c[MSB] : pred_lp;
                end
                if (upd_valid && ready_q) begin
                    u1_valid_d = 1'b1;
                    u1_idx_d   = upd_index;
                    u1_taken_d = upd_taken;
                    u1_gp_d    = upd_gp;
                    u1_lp_d    = upd_lp;
                    u1_gpc_d   = upd_gpc_c;
                    u1_cpc_d   = upd_cpc_c;
                    ghr_d      = {ghr_q[HIST_BITS-2:0], upd_taken};
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= INIT;
            init_ptr_q       <= '0;
            ghr_q            <= '0;
            ready_q          <= 1'b0;
            pred_out_valid_q <= 1'b0;
            pred_gp_q        <= 1'b0;
            pred_cp_q        <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_index_q     <= '0;
            u1_valid_q       <= 1'b0;
            u1_idx_q         <= '0;
            u1_taken_q       <= 1'b0;
            u1_gp_q          <= 1'b0;
            u1_lp_q          <= 1'b0;
            u1_gpc_q         <= '0;
            u1_cpc_q         <= '0;
        end else begin
            state_q          <= state_d;
            init_ptr_q       <= init_ptr_d;
            ghr_q            <= ghr_d;
            ready_q          <= ready_d;
            pred_out_valid_q <= pred_out_valid_d;
            pred_gp_q        <= pred_gp_d;
            pred_cp_q        <= pred_cp_d;
            pred_taken_q     <= pred_taken_d;
            pred_index_q     <= pred_index_d;
            u1_valid_q       <= u1_valid_d;
            u1_idx_q         <= u1_idx_d;
            u1_taken_q       <= u1_taken_d;
            u1_gp_q          <= u1_gp_d;
            u1_lp_q          <= u1_lp_d;
            u1_gpc_q         <= u1_gpc_d;
            u1_cpc_q         <= u1_cpc_d;
        end
    end

    assign ready          = ready_q;
    assign pred_out_valid = pred_out_valid_q;
    assign pred_gp        = pred_gp_q;
    assign pred_cp        = pred_cp_q;
    assign pred_taken     = pred_taken_q;
    assign pred_index     = pred_index_q;

endmodule

// File: tb/tb_gshare_choice_predictor.sv
// Bench for gshare_choice_predictor (HIST_BITS=4). Two instances share all
// inputs: one hashes the PC into the index, the other uses history only.
module tb_gshare_choice_predictor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_lp = 1'b0;
    logic        upd_valid = 1'b0;
    logic [3:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_gp = 1'b0;
    logic        upd_lp = 1'b0;

    logic       ready_h, pov_h, gp_h, cp_h, tk_h;
    logic [3:0] idx_h;
    logic       ready_n, pov_n, gp_n, cp_n, tk_n;
    logic [3:0] idx_n;

    gshare_choice_predictor #(.HIST_BITS(4), .CTR_BITS(2), .HASH_MODE(1), .PC_BITS(32)) dut (
        .clock(clock), .reset(reset), .ready(ready_h),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_lp(pred_lp),
        .pred_out_valid(pov_h), .pred_gp(gp_h), .pred_cp(cp_h),
        .pred_taken(tk_h), .pred_index(idx_h),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_gp(upd_gp), .upd_lp(upd_lp)
    );

    gshare_choice_predictor #(.HIST_BITS(4), .CTR_BITS(2), .HASH_MODE(0), .PC_BITS(32)) dut_nohash (
        .clock(clock), .reset(reset), .ready(ready_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_lp(pred_lp),
        .pred_out_valid(pov_n), .pred_gp(gp_n), .pred_cp(cp_n),
        .pred_taken(tk_n), .pred_index(idx_n),
        .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
        .upd_gp(upd_gp), .upd_lp(upd_lp)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] idx_h;
        logic [3:0] idx_n;
        logic       gp_h, cp_h, tk_h;
        logic       gp_n, cp_n, tk_n;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    logic [1:0] gp_m[16];
    logic [1:0] cp_m[16];
    logic [3:0] ghr_m;
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard: every result pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (pov_h === 1'b1 || pov_n === 1'b1) begin
            if (sbq.size() == 0) begin
                tests++; fails++;
                $display("FAIL pred_unexpected: pred_out_valid=%b/%b at cycle %0d, required no result", pov_h, pov_n, cyc);
            end else begin
                mon_e = sbq.pop_front();
                tests++;
                if (cyc !== mon_e.cyc || pov_h !== 1'b1 || pov_n !== 1'b1) begin
                    fails++;
                    $display("FAIL pred_latency: result at cycle %0d (valid %b/%b), required cycle %0d", cyc, pov_h, pov_n, mon_e.cyc);
                end
                tests++;
                if (idx_h !== mon_e.idx_h || idx_n !== mon_e.idx_n) begin
                    fails++;
                    $display("FAIL pred_index: got %b/%b, required %b/%b", idx_h, idx_n, mon_e.idx_h, mon_e.idx_n);
                end
                tests++;
                if ({gp_h, cp_h, tk_h} !== {mon_e.gp_h, mon_e.cp_h, mon_e.tk_h}) begin
                    fails++;
                    $display("FAIL pred_hash_gp_cp_taken: idx %b got %b%b%b, required %b%b%b", mon_e.idx_h,
                             gp_h, cp_h, tk_h, mon_e.gp_h, mon_e.cp_h, mon_e.tk_h);
                end
                tests++;
                if ({gp_n, cp_n, tk_n} !== {mon_e.gp_n, mon_e.cp_n, mon_e.tk_n}) begin
                    fails++;
                    $display("FAIL pred_nohash_gp_cp_taken: idx %b got %b%b%b, required %b%b%b", mon_e.idx_n,
                             gp_n, cp_n, tk_n, mon_e.gp_n, mon_e.cp_n, mon_e.tk_n);
                end
            end
        end
    end

    function automatic logic [31:0] pc_for(input logic [3:0] target);
        return {28'd0, ghr_m ^ target};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            gp_m[i] = 2'd0;
            cp_m[i] = 2'd0;
        end
        ghr_m = 4'd0;
    endtask

    // Drives one cycle; prediction sees state before this cycle's update.
    task automatic step(input logic pv, input logic [31:0] pc, input logic lp,
                        input logic uv, input logic [3:0] ui, input logic ut,
                        input logic ug, input logic ul);
        exp_t       e;
        logic [3:0] ih;
        pred_valid = pv; pred_pc = pc; pred_lp = lp;
        upd_valid = uv; upd_index = ui; upd_taken = ut; upd_gp = ug; upd_lp = ul;
        if (pv) begin
            ih      = ghr_m ^ pc[3:0];
            e.cyc   = cyc + 1;
            e.idx_h = ih;
            e.idx_n = ghr_m;
            e.gp_h  = gp_m[ih][1];
            e.cp_h  = cp_m[ih][1];
            e.tk_h  = cp_m[ih][1] ? gp_m[ih][1] : lp;
            e.gp_n  = gp_m[ghr_m][1];
            e.cp_n  = cp_m[ghr_m][1];
            e.tk_n  = cp_m[ghr_m][1] ? gp_m[ghr_m][1] : lp;
            sbq.push_back(e);
        end
        if (uv) begin
            if (ut) begin
                if (gp_m[ui] != 2'd3) gp_m[ui] = gp_m[ui] + 2'd1;
            end else if (gp_m[ui] != 2'd0) begin
                gp_m[ui] = gp_m[ui] - 2'd1;
            end
            if (ug == ut && ul != ut) begin
                if (cp_m[ui] != 2'd3) cp_m[ui] = cp_m[ui] + 2'd1;
            end else if (ug != ut && ul == ut) begin
                if (cp_m[ui] != 2'd0) cp_m[ui] = cp_m[ui] - 2'd1;
            end
            ghr_m = {ghr_m[2:0], ut};
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready_h !== 1'b1 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        tests++;
        if (n !== 17) begin
            fails++;
            $display("FAIL %s_ready_edges: ready rose after %0d edges, required 17", name, n);
        end
        tests++;
        if (ready_n !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready_nohash: ready=%b, required 1", name, ready_n);
        end
    endtask

    task automatic test_reset();
        // Requests held high through INIT must be ignored.
        reset = 1'b1; pred_valid = 1'b1; pred_pc = 32'h5; pred_lp = 1'b1;
        upd_valid = 1'b1; upd_index = 4'd3; upd_taken = 1'b1; upd_gp = 1'b1; upd_lp = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests++;
        if ({ready_h, pov_h, gp_h, cp_h, tk_h, idx_h} !== 9'd0) begin
            fails++;
            $display("FAIL reset_outputs: ready,valid,gp,cp,taken,index=%b%b%b%b%b %b, required all 0",
                     ready_h, pov_h, gp_h, cp_h, tk_h, idx_h);
        end
        model_clear();
        reset = 1'b0;
        wait_ready("reset");
        for (int i = 0; i < 16; i++) begin
            step(1'b1, pc_for(4'(i)), i[0], 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        end
        idle(1);
    endtask

    task automatic test_gp_saturate();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pc_for(4'd5), 1'b0, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1);
        end
        step(1'b1, pc_for(4'd5), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        // One step down from max must stay in the upper half.
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, pc_for(4'd5), 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        step(1'b1, pc_for(4'd5), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        // Underflow at zero: several not-taken then one taken stays low.
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        step(1'b1, pc_for(4'd0), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_cp();
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        step(1'b1, pc_for(4'd9), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b1);
        step(1'b1, pc_for(4'd9), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, pc_for(4'd9), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        // A single gp-right step afterwards must not yet flip CP to global.
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b1, 1'b0);
        step(1'b1, pc_for(4'd9), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_hash();
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        tests++;
        if (idx_h !== 4'b1001 || idx_n !== 4'b1010 || pov_h !== 1'b0) begin
            fails++;
            $display("FAIL hash_index_hold: index %b/%b valid %b, required 1001/1010 valid 0", idx_h, idx_n, pov_h);
        end
    endtask

    task automatic test_fwd_pred();
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd7, 1'b1, 1'b1, 1'b1);
        // GP[7] is being written 1->2 at this edge; an update also shifts GHR.
        step(1'b1, pc_for(4'd7), 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
        tests++;
        if (gp_h !== 1'b1 || idx_h !== 4'd7) begin
            fails++;
            $display("FAIL fwd_pred_gp7: gp=%b index=%b, required gp=1 index=0111", gp_h, idx_h);
        end
        step(1'b1, pc_for(4'd7), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);
    endtask

    task automatic test_reset_midrun();
        step(1'b0, 32'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1, 1'b0);
        // Reset lands with U1 and U2 both holding updates.
        pred_valid = 1'b1; pred_pc = 32'h2; upd_valid = 1'b1; upd_index = 4'd2;
        upd_taken = 1'b1; upd_gp = 1'b1; upd_lp = 1'b0; reset = 1'b1;
        @(posedge clock);
        #1;
        tests++;
        if (ready_h !== 1'b0 || ready_n !== 1'b0 || pov_h !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset_ready: ready=%b/%b valid=%b, required 0/0 0", ready_h, ready_n, pov_h);
        end
        reset = 1'b0; pred_valid = 1'b0; upd_valid = 1'b0;
        model_clear();
        wait_ready("midrun");
        step(1'b1, pc_for(4'd2), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, pc_for(4'd9), 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, pc_for(4'd5), 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_gp_saturate();
        test_cp();
        test_hash();
        test_fwd_pred();
        test_back_to_back();
        test_reset_midrun();
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL pred_missing: %0d expected results never produced, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
